// File: rtl/seq_alu.sv
// Multi-cycle ALU fed from the A/B operand registers.
// Logic/add ops finish in two cycles; MUL is a WIDTH-step shift-add with a start/done handshake.
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [OPW-1:0] OP_ADD   = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(1);
    localparam logic [OPW-1:0] OP_AND   = OPW'(2);
    localparam logic [OPW-1:0] OP_OR    = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR   = OPW'(4);
    localparam logic [OPW-1:0] OP_NOTA  = OPW'(5);
    localparam logic [OPW-1:0] OP_MUL   = OPW'(6);
    localparam logic [OPW-1:0] OP_PASSB = OPW'(7);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [OPW-1:0]       op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [CW-1:0]        counter_q, counter_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 carry_q, carry_d;

    logic [WIDTH:0]       sum_ext;
    logic [WIDTH:0]       diff_ext;
    logic [2*WIDTH-1:0]   product_next;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_carry;

    // The MSB of the extended difference is the unsigned borrow (A < B).
    always_comb begin
        sum_ext      = {1'b0, a_q} + {1'b0, b_q};
        diff_ext     = {1'b0, a_q} - {1'b0, b_q};
        product_next = b_q[0] ? (product_q + mcand_q) : product_q;
        alu_res      = '0;
        alu_carry    = 1'b0;
        case (op_q)
            OP_ADD:   begin alu_res = sum_ext[WIDTH-1:0];  alu_carry = sum_ext[WIDTH];  end
            OP_SUB:   begin alu_res = diff_ext[WIDTH-1:0]; alu_carry = diff_ext[WIDTH]; end
            OP_AND:   alu_res = a_q & b_q;
            OP_OR:    alu_res = a_q | b_q;
            OP_XOR:   alu_res = a_q ^ b_q;
            OP_NOTA:  alu_res = ~a_q;
            OP_PASSB: alu_res = b_q;
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        mcand_d   = mcand_q;
        product_d = product_q;
        counter_d = counter_q;
        result_d  = result_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d = op;
                    a_d  = dataA;
                    b_d  = dataB;
                    if (op == OP_MUL) begin
                        mcand_d   = {{WIDTH{1'b0}}, dataA};
                        product_d = '0;
                        counter_d = '0;
                        state_d   = MUL;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                result_d = alu_res;
                carry_d  = alu_carry;
                zero_d   = (alu_res == '0);
                state_d  = DONE;
            end
            MUL: begin
                // b_q doubles as the multiplier and is consumed one bit per step.
                product_d = product_next;
                mcand_d   = mcand_q << 1;
                b_d       = b_q >> 1;
                counter_d = counter_q + CW'(1);
                if (counter_q == CW'(WIDTH - 1)) begin
                    result_d = product_next[WIDTH-1:0];
                    carry_d  = |product_next[2*WIDTH-1:WIDTH];
                    zero_d   = (product_next[WIDTH-1:0] == '0);
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mcand_q   <= '0;
            product_q <= '0;
            counter_q <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            mcand_q   <= mcand_d;
            product_q <= product_d;
            counter_q <= counter_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign carry  = carry_q;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: an arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results, latencies and pulse counts.
module tb_seq_alu;

    localparam int WIDTH = 16;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_NOTA  = 3'd5;
    localparam logic [2:0] OP_MUL   = 3'd6;
    localparam logic [2:0] OP_PASSB = 3'd7;

    logic             clk;
    logic             rst;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;
    logic check_en = 1'b0;

    seq_alu #(.WIDTH(WIDTH), .OPW(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .dataA  (dataA),
        .dataB  (dataB),
        .result (result),
        .zero   (zero),
        .carry  (carry),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference result as {carry, result} from plain arithmetic on the operands.
    function automatic logic [16:0] golden(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
        int unsigned s;
        logic [31:0] p;
        logic [15:0] r;
        case (o)
            OP_ADD:   begin s = int'(a) + int'(b); r = 16'(s); return {s > 65535, r}; end
            OP_SUB:   begin r = a - b; return {a < b, r}; end
            OP_AND:   return {1'b0, a & b};
            OP_OR:    return {1'b0, a | b};
            OP_XOR:   return {1'b0, a ^ b};
            OP_NOTA:  return {1'b0, ~a};
            OP_MUL:   begin p = 32'(a) * 32'(b); return {p[31:16] != 16'h0, p[15:0]}; end
            default:  return {1'b0, b};
        endcase
    endfunction

    logic        m_busy;
    logic        m_done;
    logic        m_zero;
    logic        m_carry;
    logic [15:0] m_result;
    logic [16:0] m_pend;
    int          m_cnt;
    int          m_lat;

    // Model: an accepted op completes L edges later (1 or WIDTH) and idles one edge after that.
    always @(posedge clk) begin
        if (rst) begin
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_zero   <= 1'b0;
            m_carry  <= 1'b0;
            m_result <= 16'h0;
            m_cnt    <= 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                m_lat  <= (op == OP_MUL) ? WIDTH : 1;
                m_pend <= golden(op, dataA, dataB);
            end
        end else begin
            if (m_cnt + 1 == m_lat) begin
                m_result <= m_pend[15:0];
                m_carry  <= m_pend[16];
                m_zero   <= (m_pend[15:0] == 16'h0);
                m_done   <= 1'b1;
            end else if (m_cnt == m_lat) begin
                m_busy <= 1'b0;
                m_done <= 1'b0;
            end
            m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("cmp_busy",   busy,   m_busy);
            checkOutput("cmp_done",   done,   m_done);
            checkOutput("cmp_result", result, m_result);
            checkOutput("cmp_zero",   zero,   m_zero);
            checkOutput("cmp_carry",  carry,  m_carry);
        end
    end

    // Issues one op, scrambles the operand inputs, and follows it until busy drops.
    task automatic applyStimulus(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                                 input int inject_at, input int rst_at,
                                 output int lat, output int bc, output int dc);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        dataA = a;
        dataB = b;
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom);
        dataA = 16'($urandom);
        dataB = 16'($urandom);
        lat = 0;
        dc  = 0;
        bc  = (busy === 1'b1) ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dc++;
                if (lat == 0) lat = i;
            end
            if (busy !== 1'b1) break;
            bc++;
            if (i == inject_at) begin
                start = 1'b1;
                op    = OP_ADD;
                dataA = 16'h0001;
                dataB = 16'h0002;
            end else if (i == inject_at + 1) begin
                start = 1'b0;
            end
            if (i == rst_at) rst = 1'b1;
        end
        checkOutput("busy_bound", busy, 0);
        rst = 1'b0;
    endtask

    int lat, bc, dc;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        dataA = 16'h0;
        dataB = 16'h0;
        repeat (2) @(negedge clk);
        check_en = 1'b1;
        checkOutput("reset_busy",   busy,   0);
        checkOutput("reset_done",   done,   0);
        checkOutput("reset_result", result, 0);
        checkOutput("reset_zero",   zero,   0);
        checkOutput("reset_carry",  carry,  0);
        rst = 1'b0;

        applyStimulus(OP_ADD, 16'hFFFF, 16'h0001, -1, -1, lat, bc, dc);
        checkOutput("add_lat",    lat,    1);
        checkOutput("add_result", result, 16'h0000);
        checkOutput("add_zero",   zero,   1);
        checkOutput("add_carry",  carry,  1);
        checkOutput("add_dones",  dc,     1);

        applyStimulus(OP_SUB, 16'h0005, 16'h0007, -1, -1, lat, bc, dc);
        checkOutput("sub_result", result, 16'hFFFE);
        checkOutput("sub_zero",   zero,   0);
        checkOutput("sub_carry",  carry,  1);
        applyStimulus(OP_SUB, 16'h0007, 16'h0005, -1, -1, lat, bc, dc);
        checkOutput("sub2_result", result, 16'h0002);
        checkOutput("sub2_carry",  carry,  0);

        applyStimulus(OP_MUL, 16'h012C, 16'h00C8, -1, -1, lat, bc, dc);
        checkOutput("mul_lat",    lat,    16);
        checkOutput("mul_busy",   bc,     17);
        checkOutput("mul_result", result, 16'hEA60);
        checkOutput("mul_carry",  carry,  0);

        applyStimulus(OP_MUL, 16'h0100, 16'h0100, -1, -1, lat, bc, dc);
        checkOutput("mulov_result", result, 16'h0000);
        checkOutput("mulov_zero",   zero,   1);
        checkOutput("mulov_carry",  carry,  1);

        applyStimulus(OP_AND, 16'hFF00, 16'h0FF0, -1, -1, lat, bc, dc);
        checkOutput("and_result", result, 16'h0F00);
        checkOutput("and_carry",  carry,  0);

        applyStimulus(OP_OR, 16'hF000, 16'h000F, -1, -1, lat, bc, dc);
        checkOutput("or_result", result, 16'hF00F);
        applyStimulus(OP_XOR, 16'h00FF, 16'h0F0F, -1, -1, lat, bc, dc);
        checkOutput("xor_result", result, 16'h0FF0);
        applyStimulus(OP_NOTA, 16'h1234, 16'h5555, -1, -1, lat, bc, dc);
        checkOutput("nota_result", result, 16'hEDCB);
        applyStimulus(OP_PASSB, 16'h1111, 16'hABCD, -1, -1, lat, bc, dc);
        checkOutput("passb_result", result, 16'hABCD);
        applyStimulus(OP_PASSB, 16'h1111, 16'h0000, -1, -1, lat, bc, dc);
        checkOutput("passb_zero", zero, 1);

        applyStimulus(OP_MUL, 16'h0007, 16'h0009, 5, -1, lat, bc, dc);
        checkOutput("inject_result", result, 16'h003F);
        checkOutput("inject_dones",  dc,     1);
        checkOutput("inject_lat",    lat,    16);

        // start held through EXEC and DONE must produce exactly one operation.
        @(negedge clk);
        start = 1'b1;
        op    = OP_ADD;
        dataA = 16'h0001;
        dataB = 16'h0001;
        dc = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) dc++;
            if (i == 3) start = 1'b0;
        end
        checkOutput("hold_dones",  dc,     1);
        checkOutput("hold_result", result, 16'h0002);

        applyStimulus(OP_MUL, 16'h0003, 16'h0005, -1, 7, lat, bc, dc);
        checkOutput("abort_busy",   busy,   0);
        checkOutput("abort_done",   done,   0);
        checkOutput("abort_result", result, 0);
        checkOutput("abort_busyc",  bc,     8);
        dc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) dc++;
        end
        checkOutput("abort_nodone", dc, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
